// File: rtl/test_frame_sequencer.sv
// Test frame sequencer: loads per-channel syndrome frames, streams them to decoders, collects result
// headers and emits a report. Optional COLLECT timeout is enabled by SEQ_COLLECT_TIMEOUT_EN.
module test_frame_sequencer #(
  parameter int                    NUM_CHANNELS   = 2,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    FRAME_DEPTH    = 128,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR     = 32'hFFFFFFFF,
  parameter int                    TIMEOUT_CYCLES = 65535,
  localparam int                   CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              load_data,
  input  logic [CW-1:0]                      load_channel,
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [31:0]                        test_id,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dec_out_data,
  output logic [NUM_CHANNELS-1:0]            dec_out_valid,
  input  logic [NUM_CHANNELS-1:0]            dec_out_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] dec_in_data,
  input  logic [NUM_CHANNELS-1:0]            dec_in_valid,
  output logic [NUM_CHANNELS-1:0]            dec_in_ready,
  output logic [31:0]                        report_data,
  output logic                               report_valid,
  input  logic                               report_ready,
  output logic                               busy
);
  localparam int AW = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
  localparam int PW = $clog2(FRAME_DEPTH + 1);
  localparam int RW = $clog2(NUM_CHANNELS + 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEND    = 3'd2,
    S_COLLECT = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  state_t                                 state_q;
  logic [DATA_WIDTH-1:0]                  mem_q [NUM_CHANNELS][FRAME_DEPTH];
  logic [PW-1:0]                          wr_ptr_q [NUM_CHANNELS];
  logic [AW-1:0]                          rd_ptr_q [NUM_CHANNELS];
  logic [23:0]                            hdr_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]                closed_q, sent_q, in_closed_q, got_hdr_q, tmo_q;
  logic [NUM_CHANNELS-1:0]                out_valid_q, in_ready_q;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] out_data_q, in_data_s;
  logic [31:0]                            test_id_q, rpt_data_q, rpt_next_s;
  logic                                   rpt_valid_q;
  logic [RW-1:0]                          rpt_idx_q;
  logic                                   ch_ok_s, ld_rdy_s, ld_acc_s, rpt_done_s;
  logic                                   unused_s;

`ifdef SEQ_COLLECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES != 0);
`endif

  assign in_data_s     = dec_in_data;
  assign unused_s      = ^dec_in_data;
  assign dec_out_data  = out_data_q;
  assign dec_out_valid = out_valid_q;
  assign dec_in_ready  = in_ready_q;
  assign report_data   = rpt_data_q;
  assign report_valid  = rpt_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign load_ready    = ld_rdy_s;
  assign ld_acc_s      = load_valid && ld_rdy_s;
  assign rpt_done_s    = (state_q == S_REPORT) && rpt_valid_q && report_ready &&
                         (rpt_idx_q == RW'(NUM_CHANNELS + 1));

  // Load acceptance: only while out of reset and the addressed channel can still take a word
  always_comb begin
    ch_ok_s  = 1'b0;
    ld_rdy_s = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_ok_s = ch_ok_s | (load_channel == CW'(c));
    end
    if (reset && ch_ok_s) begin
      case (state_q)
        S_IDLE:  ld_rdy_s = 1'b1;
        S_LOAD:  ld_rdy_s = !closed_q[load_channel] &&
                            (wr_ptr_q[load_channel] != PW'(FRAME_DEPTH));
        default: ld_rdy_s = 1'b0;
      endcase
    end else begin
      ld_rdy_s = 1'b0;
    end
  end

  // Next report word: channel entry for the following index, terminator after the last channel
  always_comb begin
    rpt_next_s = 32'(TERMINATOR);
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rpt_next_s = (rpt_idx_q == RW'(c)) ? {tmo_q[c], 7'b0, hdr_q[c]} : rpt_next_s;
    end
  end

  // Sequencer FSM with frame buffers and all registered outputs; the final report handshake
  // reuses the reset path so every test starts from a clean state.
  always_ff @(posedge clk) begin
    if (!reset || rpt_done_s) begin
      state_q     <= S_IDLE;
      test_id_q   <= 32'd0;
      rpt_data_q  <= 32'd0;
      rpt_valid_q <= 1'b0;
      rpt_idx_q   <= '0;
      closed_q    <= '0;
      sent_q      <= '0;
      in_closed_q <= '0;
      got_hdr_q   <= '0;
      tmo_q       <= '0;
      out_valid_q <= '0;
      in_ready_q  <= '0;
      out_data_q  <= '0;
`ifdef SEQ_COLLECT_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        hdr_q[c]    <= 24'd0;
      end
    end else begin
      if (ld_acc_s) begin
        mem_q[load_channel][wr_ptr_q[load_channel][AW-1:0]] <= load_data;
        wr_ptr_q[load_channel] <= wr_ptr_q[load_channel] + PW'(1);
        if (load_data == TERMINATOR) begin
          closed_q[load_channel] <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (ld_acc_s) begin
            test_id_q <= test_id;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (&closed_q) begin
            state_q <= S_SEND;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              out_data_q[c]  <= mem_q[c][0];
              out_valid_q[c] <= 1'b1;
              rd_ptr_q[c]    <= AW'(1);
            end
          end
        end
        S_SEND: begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (out_valid_q[c] && dec_out_ready[c]) begin
              if (out_data_q[c] == TERMINATOR) begin
                out_valid_q[c] <= 1'b0;
                sent_q[c]      <= 1'b1;
              end else begin
                out_data_q[c] <= mem_q[c][rd_ptr_q[c]];
                rd_ptr_q[c]   <= rd_ptr_q[c] + AW'(1);
              end
            end
          end
          if (&sent_q) begin
            state_q    <= S_COLLECT;
            in_ready_q <= '1;
`ifdef SEQ_COLLECT_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
          end
        end
        S_COLLECT: begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (in_ready_q[c] && dec_in_valid[c]) begin
              if (in_data_s[c] == TERMINATOR) begin
                in_ready_q[c]  <= 1'b0;
                in_closed_q[c] <= 1'b1;
              end else if (!got_hdr_q[c]) begin
                hdr_q[c]     <= in_data_s[c][23:0];
                got_hdr_q[c] <= 1'b1;
              end
            end
          end
`ifdef SEQ_COLLECT_TIMEOUT_EN
          // Force-close stragglers; any header already captured is kept
          if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              if (!in_closed_q[c]) begin
                in_closed_q[c] <= 1'b1;
                in_ready_q[c]  <= 1'b0;
                tmo_q[c]       <= 1'b1;
              end
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
`endif
          if (&in_closed_q) begin
            state_q     <= S_REPORT;
            rpt_data_q  <= test_id_q;
            rpt_valid_q <= 1'b1;
            rpt_idx_q   <= '0;
          end
        end
        S_REPORT: begin
          if (rpt_valid_q && report_ready) begin
            rpt_idx_q  <= rpt_idx_q + RW'(1);
            rpt_data_q <= rpt_next_s;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_test_frame_sequencer.sv
// Directed self-checking bench for test_frame_sequencer (2 channels, 8-word frames, timeout 100).
module tb_test_frame_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] load_data;
  logic [0:0]  load_channel;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] test_id;
  logic [63:0] dec_out_data;
  logic [1:0]  dec_out_valid, dec_out_ready;
  logic [63:0] dec_in_data;
  logic [1:0]  dec_in_valid, dec_in_ready;
  logic [31:0] report_data;
  logic        report_valid, report_ready, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] sent0[$], sent1[$], col0[$], col1[$], rpt[$], e0[$], e1[$], er[$];

  test_frame_sequencer #(.FRAME_DEPTH(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .load_data(load_data), .load_channel(load_channel), .load_valid(load_valid),
    .load_ready(load_ready), .test_id(test_id),
    .dec_out_data(dec_out_data), .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready),
    .dec_in_data(dec_in_data), .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready),
    .report_data(report_data), .report_valid(report_valid), .report_ready(report_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic load_word(input int ch, input logic [31:0] d);
    int n = 0;
    load_channel = 1'(ch); load_data = d; load_valid = 1'b1;
    #1;
    while (!load_ready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL load_accept got stall want accept (ch %0d word %h)", ch, d); end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic do_send(output bit ok);
    ok = 1'b0; sent0 = {}; sent1 = {};
    for (int k = 0; k < 100; k++) begin
      if (dec_in_ready != 2'b00) begin ok = 1'b1; break; end
      if (dec_out_valid[0] && dec_out_ready[0]) sent0.push_back(dec_out_data[31:0]);
      if (dec_out_valid[1] && dec_out_ready[1]) sent1.push_back(dec_out_data[63:32]);
      @(negedge clk);
    end
  endtask

  task automatic run_collect(output bit ok);
    int i0 = 0;
    int i1 = 0;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      bit h0, h1;
      h0 = 1'b0; h1 = 1'b0; dec_in_valid = 2'b00;
      if (i0 < col0.size()) begin dec_in_data[31:0] = col0[i0]; dec_in_valid[0] = 1'b1; h0 = dec_in_ready[0]; end
      if (i1 < col1.size()) begin dec_in_data[63:32] = col1[i1]; dec_in_valid[1] = 1'b1; h1 = dec_in_ready[1]; end
      if (dec_in_valid == 2'b00) begin ok = 1'b1; break; end
      @(posedge clk);
      if (h0) i0++;
      if (h1) i1++;
      @(negedge clk);
    end
    dec_in_valid = 2'b00;
  endtask

  task automatic get_report(input int bound, output bit ok);
    ok = 1'b0; rpt = {}; report_ready = 1'b1;
    for (int k = 0; k < bound; k++) begin
      if (report_valid) begin rpt.push_back(report_data); ok = (rpt.size() == 4); end
      @(negedge clk);
      if (ok) break;
    end
    report_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; load_data = 32'h00000AAA; load_channel = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_load_ready got %b want 0", load_ready); end
    total++; if (dec_out_valid !== 2'b00) begin bad++; $display("FAIL rst_out_valid got %b want 00", dec_out_valid); end
    total++; if (dec_in_ready !== 2'b00) begin bad++; $display("FAIL rst_in_ready got %b want 00", dec_in_ready); end
    total++; if (report_valid !== 1'b0 || report_data !== 32'h0) begin bad++; $display("FAIL rst_report got %b/%h want 0/0", report_valid, report_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    reset = 1'b1; load_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_word_ignored got busy %b want 0", busy); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL idle_load_ready got %b want 1", load_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    bit hold;
    logic [31:0] hold_d;
    test_id = 32'd5; dec_out_ready = 2'b11;
    load_word(0, 32'h000000A1); load_word(1, 32'h000000B1); load_word(0, 32'h000000A2);
    load_word(1, 32'hFFFFFFFF);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL load_busy got %b want 1", busy); end
    load_word(0, 32'hFFFFFFFF);
    do_send(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_send_timeout got no COLLECT want COLLECT"); end
    total++; if (dec_in_ready !== 2'b11 || dec_out_valid !== 2'b00) begin bad++; $display("FAIL basic_collect_entry got %b/%b want 11/00", dec_in_ready, dec_out_valid); end
    e0 = {32'h000000A1, 32'h000000A2, 32'hFFFFFFFF}; e1 = {32'h000000B1, 32'hFFFFFFFF};
    total++; if (sent0.size() != 3 || sent1.size() != 2) begin bad++; $display("FAIL basic_send_len got %0d/%0d want 3/2", sent0.size(), sent1.size()); end
    for (int i = 0; i < 3; i++) begin total++; if (i >= sent0.size() || sent0[i] !== e0[i]) begin bad++; $display("FAIL basic_ch0_word%0d want %h", i, e0[i]); end end
    for (int i = 0; i < 2; i++) begin total++; if (i >= sent1.size() || sent1[i] !== e1[i]) begin bad++; $display("FAIL basic_ch1_word%0d want %h", i, e1[i]); end end
    col0 = {32'h00030040, 32'hDEADBEEF, 32'hFFFFFFFF}; col1 = {32'h00010020, 32'hFFFFFFFF};
    run_collect(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_collect_timeout got stall want done"); end
    er = {32'h00000005, 32'h00030040, 32'h00010020, 32'hFFFFFFFF};
    rpt = {}; report_ready = 1'b0; hold = 1'b0; hold_d = 32'h0; ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (hold && report_valid) begin
        total++; if (report_data !== hold_d) begin bad++; $display("FAIL report_hold got %h want %h", report_data, hold_d); end
      end
      hold = report_valid && !report_ready; hold_d = report_data;
      if (report_valid && report_ready) rpt.push_back(report_data);
      ok = (rpt.size() == 4);
      @(negedge clk);
      if (ok) break;
      report_ready = ~report_ready;
    end
    report_ready = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL basic_report_timeout got %0d words want 4", rpt.size()); end
    for (int i = 0; i < 4; i++) begin total++; if (i >= rpt.size() || rpt[i] !== er[i]) begin bad++; $display("FAIL basic_report_word%0d want %h", i, er[i]); end end
    total++; if (busy !== 1'b0 || report_valid !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL basic_back_idle got busy %b rv %b lr %b want 0 0 1", busy, report_valid, load_ready); end
  endtask

  task automatic test_reset_send();
    bit tg = 1'b0;
    logic [1:0] hold;
    logic [63:0] hold_d;
    int n = 0;
    test_id = 32'd7; report_ready = 1'b0; dec_out_ready = 2'b00;
    load_word(0, 32'h000000D1); load_word(0, 32'h000000D2); load_word(0, 32'h000000D3);
    load_word(1, 32'h000000E1); load_word(1, 32'hFFFFFFFF); load_word(0, 32'hFFFFFFFF);
    while (dec_out_valid == 2'b00 && n < 10) begin @(negedge clk); n++; end
    total++; if (dec_out_valid !== 2'b11) begin bad++; $display("FAIL send_start got %b want 11", dec_out_valid); end
    hold = 2'b00; hold_d = 64'h0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c]) begin
          total++; if (dec_out_data[c*32 +: 32] !== hold_d[c*32 +: 32]) begin bad++; $display("FAIL out_hold ch%0d got %h want %h", c, dec_out_data[c*32 +: 32], hold_d[c*32 +: 32]); end
        end
      end
      dec_out_ready = {tg, ~tg}; tg = ~tg;
      hold = dec_out_valid & ~dec_out_ready; hold_d = dec_out_data;
      @(negedge clk);
    end
    reset = 1'b0; dec_out_ready = {tg, ~tg};
    @(negedge clk);
    total++; if (dec_out_valid !== 2'b00 || dec_in_ready !== 2'b00) begin bad++; $display("FAIL midrst_streams got %b/%b want 00/00", dec_out_valid, dec_in_ready); end
    total++; if (report_valid !== 1'b0 || report_data !== 32'h0 || busy !== 1'b0 || load_ready !== 1'b0) begin bad++; $display("FAIL midrst_outputs got rv %b rd %h busy %b lr %b want 0 0 0 0", report_valid, report_data, busy, load_ready); end
    reset = 1'b1; dec_out_ready = 2'b11;
    @(negedge clk);
  endtask

  task automatic test_term_only();
    bit ok;
    test_id = 32'd9; dec_out_ready = 2'b11;
    load_word(1, 32'hFFFFFFFF); load_word(0, 32'h000000C1); load_word(0, 32'hFFFFFFFF);
    do_send(ok);
    total++; if (!ok) begin bad++; $display("FAIL term_send_timeout got no COLLECT want COLLECT"); end
    total++; if (sent1.size() != 1 || sent0.size() != 2) begin bad++; $display("FAIL term_send_len got %0d/%0d want 2/1", sent0.size(), sent1.size()); end
    total++; if (sent1.size() < 1 || sent1[0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL term_ch1_word want ffffffff"); end
    col0 = {32'h00050007, 32'hFFFFFFFF}; col1 = {32'hFFFFFFFF};
    run_collect(ok);
    get_report(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL term_report_timeout got %0d words want 4", rpt.size()); end
    er = {32'h00000009, 32'h00050007, 32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin total++; if (i >= rpt.size() || rpt[i] !== er[i]) begin bad++; $display("FAIL term_report_word%0d want %h", i, er[i]); end end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) load_word(0, 32'h00000100 + i);
    load_channel = 1'b0; load_data = 32'h00000999; load_valid = 1'b1;
    #1;
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", load_ready); end
    @(negedge clk); @(negedge clk);
    total++; if (load_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL full_stall got lr %b busy %b want 0 1", load_ready, busy); end
    load_valid = 1'b0;
    load_word(1, 32'hFFFFFFFF);
    load_channel = 1'b1; load_data = 32'h00000777; load_valid = 1'b1;
    #1;
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL closed_ready got %b want 0", load_ready); end
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL load_reset got busy %b want 0", busy); end
  endtask

  task automatic test_full_frame();
    bit ok;
    test_id = 32'h00000077; dec_out_ready = 2'b11;
    load_word(1, 32'hFFFFFFFF);
    test_id = 32'h00000099;
    for (int i = 0; i < 7; i++) load_word(0, 32'h00000200 + i);
    load_word(0, 32'hFFFFFFFF);
    do_send(ok);
    total++; if (!ok || sent0.size() != 8 || sent1.size() != 1) begin bad++; $display("FAIL fullf_send_len got %0d/%0d want 8/1", sent0.size(), sent1.size()); end
    total++; if (sent0.size() < 8 || sent0[6] !== 32'h00000206 || sent0[7] !== 32'hFFFFFFFF) begin bad++; $display("FAIL fullf_tail want 00000206 ffffffff"); end
    col0 = {32'hFFFFFFFF}; col1 = {32'hAB0F1234, 32'h00000005, 32'hFFFFFFFF};
    run_collect(ok);
    get_report(40, ok);
    er = {32'h00000077, 32'h00000000, 32'h000F1234, 32'hFFFFFFFF};
    total++; if (!ok) begin bad++; $display("FAIL fullf_report_timeout got %0d words want 4", rpt.size()); end
    for (int i = 0; i < 4; i++) begin total++; if (i >= rpt.size() || rpt[i] !== er[i]) begin bad++; $display("FAIL fullf_report_word%0d want %h", i, er[i]); end end
  endtask

`ifdef SEQ_COLLECT_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int c0;
    int n = 0;
    test_id = 32'h00000033; dec_out_ready = 2'b11;
    load_word(0, 32'h000000F1); load_word(1, 32'hFFFFFFFF); load_word(0, 32'hFFFFFFFF);
    do_send(ok);
    c0 = cyc;
    col0 = {32'h00020011, 32'hFFFFFFFF}; col1 = {};
    run_collect(ok);
    while (!report_valid && n < 300) begin @(negedge clk); n++; end
    total++; if (cyc - c0 < 99 || cyc - c0 > 102) begin bad++; $display("FAIL tmo_latency got %0d want 99..102", cyc - c0); end
    get_report(40, ok);
    er = {32'h00000033, 32'h00020011, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin total++; if (i >= rpt.size() || rpt[i] !== er[i]) begin bad++; $display("FAIL tmo_report_word%0d want %h", i, er[i]); end end
  endtask
`endif

  initial begin
    reset = 1'b0; load_data = 32'h0; load_channel = 1'b0; load_valid = 1'b0; test_id = 32'h0;
    dec_out_ready = 2'b00; dec_in_data = 64'h0; dec_in_valid = 2'b00; report_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_reset_send();
    test_term_only();
    test_overflow();
    test_full_frame();
`ifdef SEQ_COLLECT_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
